// File: rtl/saper_pkg.sv
// Shared types and constants for the mine placement logic.
// Latency: n/a (package only).
// Backpressure: n/a.
package saper_pkg;

    // Maximum buttons per board side; the mine map is MAX_GRID x MAX_GRID bits.
    localparam int          MAX_GRID = 16;
    localparam logic [4:0]  MAX_N    = 5'(MAX_GRID);

    // Fibonacci feedback taps at stages 16,14,13,11 (bits 15,13,12,10).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        PLACE = 2'd2,
        DONE  = 2'd3
    } gen_state_t;

    typedef logic [MAX_GRID-1:0][MAX_GRID-1:0] mine_map_t;

    // Number of mines actually placed for a requested count on an n x n board.
    // An unusable board size yields zero mines; a full board is never allowed,
    // so a 1x1 board also ends up with zero mines.
    function automatic logic [5:0] clamp_target(input logic [5:0] mines, input logic [4:0] n);
        logic [8:0] w_cells;
        logic [8:0] w_limit;
        w_cells = {4'd0, n} * {4'd0, n};
        w_limit = w_cells - 9'd1;
        if (n == 5'd0 || n > MAX_N) begin
            return 6'd0;
        end else if ({3'd0, mines} >= w_cells) begin
            return w_limit[5:0];
        end else begin
            return mines;
        end
    endfunction

endpackage

// File: rtl/mine_generator_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; shifts left, feedback enters bit 0.
// Latency: new state every cycle, reset loads SEED (zero seed forced to 1).
// Backpressure: none, never stalls.
// Ports: clk, rst (sync active-high), o_state (current 16-bit state).
module lfsr16
    import saper_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = LFSR_TAPS
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] o_state
);

    // An all-zero state would lock the register up, so it is never loaded.
    localparam logic [15:0] SEED_NZ = (SEED == 16'd0) ? 16'h0001 : SEED;

    logic [15:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED_NZ;
        end else begin
            r_state <= {r_state[14:0], ^(r_state & TAPS)};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/mine_generator.sv
// Places the requested number of distinct mines on an n x n board using LFSR candidates.
// Latency: one candidate per cycle after a 1-cycle clear; read port has 1-cycle latency.
// Backpressure: none; a new level_enable strobe in any state restarts placement.
// Ports: clk, rst, level_enable, mines_in[5:0], button_num[4:0] (level config);
//        rd_x/rd_y -> rd_mine (registered lookup); gen_busy, gen_done, mines_placed (status).
module mine_generator
    import saper_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level_enable,
    input  logic [5:0] mines_in,
    input  logic [4:0] button_num,
    input  logic [4:0] rd_x,
    input  logic [4:0] rd_y,
    output logic       rd_mine,
    output logic       gen_busy,
    output logic       gen_done,
    output logic [5:0] mines_placed
);

    gen_state_t  r_state;
    gen_state_t  w_state_next;

    logic [15:0] w_lfsr;
    logic [7:0]  w_lfsr_unused;
    logic [3:0]  w_cand_x;
    logic [3:0]  w_cand_y;
    logic        w_cand_ok;
    logic        w_full;
    logic        w_clear;
    logic        w_accept;
    logic        w_rd_hit;

    logic [4:0]  r_n;
    logic [5:0]  r_target;
    mine_map_t   r_map;
    logic [5:0]  r_placed;
    logic        r_busy;
    logic        r_done;
    logic        r_rd_mine;

    lfsr16 #(
        .SEED (LFSR_SEED),
        .TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .o_state (w_lfsr)
    );

    // Only the low byte feeds candidate coordinates.
    assign w_lfsr_unused = w_lfsr[15:8];
    assign w_cand_x      = w_lfsr[3:0];
    assign w_cand_y      = w_lfsr[7:4];

    assign w_cand_ok = ({1'b0, w_cand_x} < r_n) &&
                       ({1'b0, w_cand_y} < r_n) &&
                       !r_map[w_cand_y][w_cand_x];
    assign w_full    = (r_placed == r_target);

    // r_n is stored as 0 for unusable sizes, so the bound check also keeps the
    // 4-bit index inside the map.
    assign w_rd_hit  = (rd_x < r_n && rd_y < r_n) ? r_map[rd_y[3:0]][rd_x[3:0]] : 1'b0;

    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_accept     = 1'b0;
        if (level_enable) begin
            // A strobe in any state (re)starts from CLEAR; it also beats a
            // final accept in the same cycle.
            w_state_next = CLEAR;
        end else begin
            case (r_state)
                IDLE:  w_state_next = IDLE;
                CLEAR: begin
                    w_state_next = PLACE;
                    w_clear      = 1'b1;
                end
                PLACE: begin
                    if (w_full) begin
                        w_state_next = DONE;
                    end else begin
                        w_accept = w_cand_ok;
                    end
                end
                DONE:  w_state_next = DONE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_n       <= 5'd0;
            r_target  <= 6'd0;
            r_map     <= '0;
            r_placed  <= 6'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rd_mine <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            // Status flags follow the state being entered so they line up with it.
            r_busy    <= (w_state_next == CLEAR) || (w_state_next == PLACE);
            r_done    <= (w_state_next == DONE);
            r_rd_mine <= w_rd_hit;

            if (level_enable) begin
                r_n      <= (button_num == 5'd0 || button_num > MAX_N) ? 5'd0 : button_num;
                r_target <= clamp_target(mines_in, button_num);
            end

            if (w_clear) begin
                r_map    <= '0;
                r_placed <= 6'd0;
            end else if (w_accept) begin
                r_map[w_cand_y][w_cand_x] <= 1'b1;
                r_placed                  <= r_placed + 6'd1;
            end
        end
    end

    assign rd_mine      = r_rd_mine;
    assign gen_busy     = r_busy;
    assign gen_done     = r_done;
    assign mines_placed = r_placed;

endmodule

// File: tb/tb_mine_generator.sv
// Self-checking bench for mine_generator: cycle model plus directed level scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_mine_generator;

    logic       clk;
    logic       rst;
    logic       level_enable;
    logic [5:0] mines_in;
    logic [4:0] button_num;
    logic [4:0] rd_x;
    logic [4:0] rd_y;
    logic       rd_mine;
    logic       gen_busy;
    logic       gen_done;
    logic [5:0] mines_placed;

    int checks   = 0;
    int failures = 0;

    localparam int K_IDLE = 5;

    mine_generator #(.LFSR_SEED(16'hACE1)) dut (
        .clk          (clk),
        .rst          (rst),
        .level_enable (level_enable),
        .mines_in     (mines_in),
        .button_num   (button_num),
        .rd_x         (rd_x),
        .rd_y         (rd_y),
        .rd_mine      (rd_mine),
        .gen_busy     (gen_busy),
        .gen_done     (gen_done),
        .mines_placed (mines_placed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[16-1] ^ s[14-1] ^ s[13-1] ^ s[11-1];
        return {s[14:0], fb};
    endfunction

    function automatic int exp_target(input int mines, input int n);
        if (n < 1 || n > 16) return 0;
        if (mines >= n * n) return n * n - 1;
        return mines;
    endfunction

    int          m_phase;   // 0 idle, 1 clearing, 2 placing, 3 done
    bit          m_map [16][16];
    int          m_n, m_target, m_placed;
    logic [15:0] m_lfsr;
    bit          m_busy, m_done, m_rd;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase  = 0;
            m_n      = 0;
            m_target = 0;
            m_placed = 0;
            m_lfsr   = 16'hACE1;
            m_busy   = 0;
            m_done   = 0;
            m_rd     = 0;
            foreach (m_map[y, x]) m_map[y][x] = 0;
            m_valid  = 1'b1;
        end else begin
            int cx, cy;
            cx = int'(m_lfsr[3:0]);
            cy = int'(m_lfsr[7:4]);
            m_rd = 0;
            if (int'(rd_x) < m_n && int'(rd_y) < m_n) m_rd = m_map[rd_y][rd_x];
            if (level_enable) begin
                m_phase  = 1;
                m_n      = (button_num >= 1 && button_num <= 16) ? int'(button_num) : 0;
                m_target = exp_target(int'(mines_in), int'(button_num));
            end else if (m_phase == 1) begin
                foreach (m_map[y, x]) m_map[y][x] = 0;
                m_placed = 0;
                m_phase  = 2;
            end else if (m_phase == 2) begin
                if (m_placed == m_target) begin
                    m_phase = 3;
                end else if (cx < m_n && cy < m_n && !m_map[cy][cx]) begin
                    m_map[cy][cx] = 1;
                    m_placed++;
                end
            end
            m_busy = (m_phase == 1 || m_phase == 2);
            m_done = (m_phase == 3);
            m_lfsr = lfsr_step(m_lfsr);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_gen_busy", int'(gen_busy), int'(m_busy));
            chk("model_gen_done", int'(gen_done), int'(m_done));
            chk("model_mines_placed", int'(mines_placed), m_placed);
            chk("model_rd_mine", int'(rd_mine), int'(m_rd));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic strobe(input int mines, input int n);
        level_enable = 1'b1;
        mines_in     = 6'(mines);
        button_num   = 5'(n);
        tick();
        level_enable = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget && !gen_done; i++) tick();
        if (!gen_done) chk({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic wait_placed(input string name, input int cnt, input int budget);
        int i;
        for (i = 0; i < budget && int'(mines_placed) < cnt; i++) tick();
        if (int'(mines_placed) < cnt) chk({name, "_placed_timeout"}, int'(mines_placed), cnt);
    endtask

    bit cur_map [16][16];
    bit map_a   [16][16];

    // Reads the whole 16x16 map through the lookup port; returns popcount
    // and the number of set bits outside the n x n board.
    task automatic sweep(input int n, output int pop, output int outside);
        pop = 0;
        outside = 0;
        for (int y = 0; y < 16; y++) begin
            for (int x = 0; x < 16; x++) begin
                rd_x = 5'(x);
                rd_y = 5'(y);
                tick();
                cur_map[y][x] = rd_mine;
                if (rd_mine) begin
                    pop++;
                    if (x >= n || y >= n) outside++;
                end
            end
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int pop, outside, nb, diff;
        rst          = 1'b1;
        level_enable = 1'b0;
        mines_in     = 6'd0;
        button_num   = 5'd0;
        rd_x         = 5'd0;
        rd_y         = 5'd0;

        // Pin the model against hand-computed values.
        chk("pin_lfsr_step", int'(lfsr_step(16'hACE1)), 16'h59C3);
        chk("pin_clamp_4x4", exp_target(63, 4), 15);
        chk("pin_clamp_1x1", exp_target(8, 1), 0);
        chk("pin_clamp_n20", exp_target(5, 20), 0);

        do_reset();
        chk("reset_busy", int'(gen_busy), 0);
        chk("reset_done", int'(gen_done), 0);
        chk("reset_placed", int'(mines_placed), 0);
        chk("reset_rd_mine", int'(rd_mine), 0);

        // Level 1
        repeat (K_IDLE) tick();
        strobe(8, 8);
        chk("l1_busy_next", int'(gen_busy), 1);
        wait_done("l1", 2000);
        chk("l1_placed", int'(mines_placed), 8);
        sweep(8, pop, outside);
        chk("l1_popcount", pop, 8);
        chk("l1_outside", outside, 0);
        foreach (cur_map[y, x]) map_a[y][x] = cur_map[y][x];

        // Level 3
        strobe(60, 16);
        wait_done("l3", 5000);
        chk("l3_placed", int'(mines_placed), 60);
        sweep(16, pop, outside);
        chk("l3_popcount", pop, 60);
        rd_x = 5'd17;
        rd_y = 5'd0;
        tick();
        chk("l3_rd_x17", int'(rd_mine), 0);
        rd_x = 5'd3;
        rd_y = 5'd17;
        tick();
        chk("l3_rd_y17", int'(rd_mine), 0);

        // Clamp
        strobe(63, 4);
        wait_done("clamp", 20000);
        chk("clamp_placed", int'(mines_placed), 15);
        sweep(4, pop, outside);
        chk("clamp_popcount", pop, 15);
        chk("clamp_outside", outside, 0);

        // Degenerate: zero board size, then zero mines
        for (int k = 0; k < 2; k++) begin
            if (k == 0) strobe(10, 0);
            else        strobe(0, 8);
            nb = 0;
            for (int i = 0; i < 10 && !gen_done; i++) begin
                if (gen_busy) nb++;
                tick();
            end
            chk("degen_busy_cycles", nb, 2);
            chk("degen_done", int'(gen_done), 1);
            chk("degen_placed", int'(mines_placed), 0);
        end

        // Restart mid-placement
        strobe(60, 16);
        wait_placed("restart", 30, 3000);
        strobe(20, 10);
        chk("restart_cleared_busy", int'(gen_busy), 1);
        wait_done("restart", 5000);
        chk("restart_placed", int'(mines_placed), 20);
        sweep(10, pop, outside);
        chk("restart_popcount", pop, 20);
        chk("restart_outside", outside, 0);

        // Reset during PLACE, then reproduce Level 1 with identical timing
        strobe(60, 16);
        wait_placed("rstmid", 10, 3000);
        rd_x = 5'd1;
        rd_y = 5'd1;
        rst  = 1'b1;
        tick();
        chk("rstmid_busy", int'(gen_busy), 0);
        chk("rstmid_done", int'(gen_done), 0);
        chk("rstmid_placed", int'(mines_placed), 0);
        chk("rstmid_rd_mine", int'(rd_mine), 0);
        tick();
        rst = 1'b0;
        repeat (K_IDLE) tick();
        strobe(8, 8);
        wait_done("repro", 2000);
        chk("repro_placed", int'(mines_placed), 8);
        sweep(8, pop, outside);
        diff = 0;
        foreach (cur_map[y, x]) if (cur_map[y][x] != map_a[y][x]) diff++;
        chk("repro_map_diff", diff, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
